regfile_port3_arbiter: RTL and testbench
========================================

Name: regfile_port3_arbiter

Overview:
Shares the register file's single write/third-read port (wre, a3, wd3, rd3) between three requesters: the ALU writeback, the memory-load writeback and a port-3 read requester. Each writeback source has a one-entry holding slot. A registered issue stage drives the regfile every cycle. A per-register pending vector lets decode stall on in-flight writes, and a read is never issued against an address with a write in flight.

Parameters:
DATA_W, 16, regfile data width
ADDR_W, 4, regfile address width
NREG, 16, number of registers (2**ADDR_W)
STARVE_MAX, 4, max consecutive write issues while a read waits

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU slot can accept this cycle
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load writeback request
mem_ready  out  1  load slot can accept this cycle
mem_addr  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
rd_valid  in  1  port-3 read request
rd_ready  out  1  read granted this cycle
rd_addr  in  ADDR_W  read address
rd_data_valid  out  1  rd_data valid this cycle
rd_data  out  DATA_W  read result (passthrough of rf_rd3)
rf_wre  out  1  regfile write enable
rf_a3  out  ADDR_W  regfile port-3 address (write or read)
rf_wd3  out  DATA_W  regfile write data
rf_rd3  in  DATA_W  regfile port-3 read data (combinational)
pending  out  NREG  bit i set while a write to register i is buffered or issuing
idle  out  1  both slots empty and issue stage idle

Behaviour:
- Reset (async, rst_n=0): both slots empty; issue stage idle; rf_wre=0, rf_a3=0, rf_wd3=0, rd_data_valid=0; round-robin pointer = ALU; starve counter = 0. Outputs: alu_ready=mem_ready=1, rd_ready=0, pending=0, idle=1. Reset mid-operation discards buffered and issuing writes; no write reaches the regfile after rst_n falls.
- Slots: a handshake (valid&ready at an edge) loads the slot. slot_ready = slot empty OR slot wins arbitration this cycle, so each source sustains one write per cycle while it keeps winning.
- Arbitration is combinational each cycle over {ALU slot, MEM slot, read request}. The winner is loaded into the issue register at the next edge.
  - Writes beat reads unless the starve counter equals STARVE_MAX with rd_valid held.
  - ALU vs MEM with both slots full: round-robin. The pointer flips to the other source after each write grant.
- Read eligibility: rd_valid=1 AND pending[rd_addr]=0. rd_ready=1 only when the read wins. A read request is not buffered.
- Starve counter: increments on each write issue while an eligible read waits. Clears on read issue or when no eligible read is waiting. Saturates at STARVE_MAX.
- Issue stage, one cycle per entry. Issue kinds:
  - IDLE: rf_wre=0; rf_a3 and rf_wd3 hold their previous values.
  - WR_ALU / WR_MEM: rf_wre=1, rf_a3=slot addr, rf_wd3=slot data. The regfile writes at the edge ending the cycle.
  - RD: rf_wre=0, rf_a3=rd_addr, rd_data_valid=1, rd_data=rf_rd3 in the same cycle.
- Latency:
  - Write: accepted at edge E0, rf_wre high during E1..E2 at the earliest, regfile updated at E2.
  - Read: granted at E0, data valid in cycle E0..E1.
- pending is combinational: OR of one-hot(addr) over full slots and a write in the issue stage. The bit clears in the cycle after the regfile write edge.
- Both sources targeting the same register: writes land in grant order. pending stays set until the last one completes.
- Read-after-write: a read of a register pending in any stage waits. It issues no earlier than the cycle after the write edge, so it always returns the new value.
- idle = both slots empty AND issue kind IDLE.

Decomposition:
- Package regfile_ctrl_pkg: DATA_W/ADDR_W/NREG defaults and enum issue_kind_t {ISS_IDLE, ISS_WR_ALU, ISS_WR_MEM, ISS_RD}.
- Sub-module wb_slot: one-entry holding register with valid/ready, addr/data and a drain input, instantiated twice.
- Arbitration, starve counter, issue register and pending decode live in the top module.

Test Plan:
- Reset then ALU write r11←0x0008 at E0 -> rf_wre=1, rf_a3=11, rf_wd3=0x0008 in cycle E1; pending[11]=1 from E0+ until after E2; idle=1 after.
- ALU r9←0x1111 and MEM r7←0x2222 accepted same edge -> ALU issued first, MEM next cycle. A second simultaneous pair -> MEM issued first (round-robin).
- Pending ALU r9←0xBEEF with read rd_addr=9 asserted -> rd_ready=0 until r9 is written; then read issues, rd_data=0xBEEF with rd_data_valid=1.
- Both sources stream back-to-back writes to r1..r8 while read of r15 is held -> read granted after exactly STARVE_MAX=4 write issues; no write lost or reordered per source.
- ALU and MEM both write r3 (0xAAAA then 0xBBBB, ALU granted first) -> regfile r3 ends at 0xBBBB; pending[3] clears only after the second write.
- rst_n driven low while both slots are full and a write is issuing -> all outputs return to reset values immediately; a following read of those registers returns the pre-reset contents.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default sizes for the regfile port-3 arbiter.
// issue_kind_t names what the issue stage drives onto port 3.
package regfile_ctrl_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_ADDR_W     = 4;
    localparam int DEF_NREG       = 16;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ISS_IDLE,
        ISS_WR_ALU,
        ISS_WR_MEM,
        ISS_RD
    } issue_kind_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot.
// Ports: push_valid/push_ready/push_addr/push_data load the slot,
// drain empties it, full/addr/data expose the held entry.
module wb_slot #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              drain,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // A draining slot can be refilled on the same edge.
    assign push_ready = !full || drain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (push_valid && push_ready) begin
            full <= 1'b1;
            addr <= push_addr;
            data <= push_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_port3_arbiter.sv
// Shares regfile write/third-read port between ALU writeback, load
// writeback and a port-3 reader. Ports: alu_*, mem_* writeback
// handshakes; rd_* read request/result; rf_* regfile port 3;
// pending marks registers with writes in flight; idle when empty.
module regfile_port3_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NREG       = DEF_NREG,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rf_wre,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    input  logic [DATA_W-1:0] rf_rd3,
    output logic [NREG-1:0]   pending,
    output logic              idle
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

    logic              alu_full;
    logic              mem_full;
    logic [ADDR_W-1:0] alu_q_addr;
    logic [ADDR_W-1:0] mem_q_addr;
    logic [DATA_W-1:0] alu_q_data;
    logic [DATA_W-1:0] mem_q_data;
    logic              grant_alu;
    logic              grant_mem;
    logic              grant_rd;
    logic              rd_elig;
    logic              starved;
    logic              issue_wr;
    issue_kind_t       kind_q;
    logic [ADDR_W-1:0] a3_q;
    logic [DATA_W-1:0] wd3_q;
    logic              rr_mem;
    logic [CNT_W-1:0]  starve_q;

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (alu_valid),
        .push_ready (alu_ready),
        .push_addr  (alu_addr),
        .push_data  (alu_data),
        .drain      (grant_alu),
        .full       (alu_full),
        .addr       (alu_q_addr),
        .data       (alu_q_data)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (mem_valid),
        .push_ready (mem_ready),
        .push_addr  (mem_addr),
        .push_data  (mem_data),
        .drain      (grant_mem),
        .full       (mem_full),
        .addr       (mem_q_addr),
        .data       (mem_q_data)
    );

    assign issue_wr = (kind_q == ISS_WR_ALU) || (kind_q == ISS_WR_MEM);

    // Includes the issuing write so a read waits past the write edge.
    always_comb begin
        pending = '0;
        if (alu_full) pending[alu_q_addr] = 1'b1;
        if (mem_full) pending[mem_q_addr] = 1'b1;
        if (issue_wr) pending[a3_q] = 1'b1;
    end

    assign rd_elig = rd_valid && !pending[rd_addr];
    assign starved = (starve_q == STARVE_TOP);

    // rr_mem=1 means MEM wins the next contended write grant.
    assign grant_rd  = rd_elig && (!(alu_full || mem_full) || starved);
    assign grant_alu = !grant_rd && alu_full && (!mem_full || !rr_mem);
    assign grant_mem = !grant_rd && mem_full && (!alu_full || rr_mem);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q   <= ISS_IDLE;
            a3_q     <= '0;
            wd3_q    <= '0;
            rr_mem   <= 1'b0;
            starve_q <= '0;
        end else begin
            if (grant_alu) begin
                kind_q <= ISS_WR_ALU;
                a3_q   <= alu_q_addr;
                wd3_q  <= alu_q_data;
                rr_mem <= 1'b1;
            end else if (grant_mem) begin
                kind_q <= ISS_WR_MEM;
                a3_q   <= mem_q_addr;
                wd3_q  <= mem_q_data;
                rr_mem <= 1'b0;
            end else if (grant_rd) begin
                kind_q <= ISS_RD;
                a3_q   <= rd_addr;
            end else begin
                kind_q <= ISS_IDLE;
            end

            if (grant_rd || !rd_elig) begin
                starve_q <= '0;
            end else if ((grant_alu || grant_mem) && !starved) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

    assign rf_wre        = issue_wr;
    assign rf_a3         = a3_q;
    assign rf_wd3        = wd3_q;
    assign rd_ready      = grant_rd;
    assign rd_data_valid = (kind_q == ISS_RD);
    assign rd_data       = rf_rd3;
    assign idle          = !alu_full && !mem_full && (kind_q == ISS_IDLE);

endmodule

// File: tb/tb_regfile_port3_arbiter.sv
// Bench for regfile_port3_arbiter: vector table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_regfile_port3_arbiter;

    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int NR   = 16;
    localparam int SMAX = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        bit            is_rd;
        bit            on_mem;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          rd_valid, rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data;
    logic          rf_wre;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd3;
    logic [DW-1:0] rf_rd3;
    logic [NR-1:0] pending;
    logic          idle;

    logic          clr_mem;
    logic [DW-1:0] rf_mem [NR];
    logic [AW+DW-1:0] wlog [$];
    wr_t           aq [$];
    wr_t           mq [$];
    int            total = 0;
    int            bad = 0;

    regfile_port3_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .rf_wre        (rf_wre),
        .rf_a3         (rf_a3),
        .rf_wd3        (rf_wd3),
        .rf_rd3        (rf_rd3),
        .pending       (pending),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    // Register file the arbiter drives.
    assign rf_rd3 = rf_mem[rf_a3];

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < NR; i++) rf_mem[i] <= '0;
        end else if (rf_wre) begin
            rf_mem[rf_a3] <= rf_wd3;
            wlog.push_back({rf_a3, rf_wd3});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!idle && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, idle, 1);
    endtask

    task automatic do_read(input string name, input logic [AW-1:0] a,
                           input logic [DW-1:0] exp);
        int n = 0;
        @(negedge clk);
        rd_valid = 1'b1;
        rd_addr  = a;
        #1;
        while (!rd_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_grant"}, rd_ready, 1);
        @(negedge clk);
        rd_valid = 1'b0;
        chk({name, "_valid"}, rd_data_valid, 1);
        chk({name, "_addr"}, rf_a3, a);
        chk({name, "_data"}, rd_data, exp);
    endtask

    // Presents one write on each source in the same cycle.
    task automatic push_pair(input string name,
                             input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                             input logic [AW-1:0] ma, input logic [DW-1:0] md);
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = aa; alu_data = ad;
        mem_valid = 1'b1; mem_addr = ma; mem_data = md;
        #1;
        chk({name, "_ardy"}, alu_ready, 1);
        chk({name, "_mrdy"}, mem_ready, 1);
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic push_one(input bit on_mem, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        @(negedge clk);
        alu_valid = !on_mem; alu_addr = a; alu_data = d;
        mem_valid = on_mem;  mem_addr = a; mem_data = d;
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    function automatic logic [NR-1:0] exp_pend();
        logic [NR-1:0] p = '0;
        foreach (aq[i]) p[aq[i].a] = 1'b1;
        foreach (mq[i]) p[mq[i].a] = 1'b1;
        return p;
    endfunction

    function automatic bit busy(input logic [AW-1:0] a);
        logic [NR-1:0] p = exp_pend();
        return p[a];
    endfunction

    task automatic check_reset_outs(input string name);
        chk({name, "_ardy"}, alu_ready, 1);
        chk({name, "_mrdy"}, mem_ready, 1);
        chk({name, "_rrdy"}, rd_ready, 0);
        chk({name, "_pend"}, pending, 0);
        chk({name, "_idle"}, idle, 1);
        chk({name, "_wre"}, rf_wre, 0);
        chk({name, "_a3"}, rf_a3, 0);
        chk({name, "_wd3"}, rf_wd3, 0);
        chk({name, "_rdv"}, rd_data_valid, 0);
    endtask

    // Outstanding writes per source live in aq/mq from acceptance
    // until the edge that writes them into the register file.
    task automatic rand_phase(input int ncyc);
        logic [DW-1:0] model [NR];
        int            starve = 0;
        int            slots;
        bit            prev_elig = 0, prev_rg = 0, last_rg = 0;
        bit            acc_a = 0, acc_m = 0, rg = 0, elig, wre, ok, quiet;
        logic [AW-1:0] last_ra = '0, wa;
        logic [DW-1:0] wd;
        for (int i = 0; i < NR; i++) model[i] = rf_mem[i];
        for (int c = 0; c < ncyc + 40; c++) begin
            quiet = (c >= ncyc);
            @(negedge clk);
            chk("rnd_pending", pending, exp_pend());
            chk("rnd_rdv", rd_data_valid, last_rg);
            if (last_rg) begin
                chk("rnd_rd_a3", rf_a3, last_ra);
                chk("rnd_rdata", rd_data, model[last_ra]);
            end
            if (!alu_valid || acc_a) begin
                alu_valid = !quiet && ($urandom_range(0, 99) < 55);
                alu_addr  = AW'($urandom_range(0, NR - 1));
                alu_data  = DW'($urandom);
            end
            if (!mem_valid || acc_m) begin
                mem_valid = !quiet && ($urandom_range(0, 99) < 55);
                mem_addr  = AW'($urandom_range(0, NR - 1));
                mem_data  = DW'($urandom);
            end
            if (!rd_valid || rg) begin
                rd_valid = !quiet && ($urandom_range(0, 99) < 35);
                rd_addr  = AW'($urandom_range(0, NR - 1));
            end
            #1;
            acc_a = alu_valid && alu_ready;
            acc_m = mem_valid && mem_ready;
            rg    = rd_valid && rd_ready;
            wre   = rf_wre;
            wa    = rf_a3;
            wd    = rf_wd3;
            elig  = rd_valid && !busy(rd_addr);
            slots = aq.size() + mq.size() - (wre ? 1 : 0);
            if (prev_rg || !prev_elig) starve = 0;
            else if (wre && starve < SMAX) starve++;
            if (rd_valid && !elig) chk("rnd_rd_hazard", rg, 0);
            if (elig && slots == 0) chk("rnd_rd_free", rg, 1);
            if (elig && slots > 0) chk("rnd_rd_prio", rg, starve == SMAX);
            prev_elig = elig;
            prev_rg   = rg;
            @(posedge clk);
            if (wre) begin
                ok = 0;
                if (aq.size() > 0 && aq[0].a == wa && aq[0].d == wd) begin
                    void'(aq.pop_front());
                    ok = 1;
                end else if (mq.size() > 0 && mq[0].a == wa && mq[0].d == wd) begin
                    void'(mq.pop_front());
                    ok = 1;
                end
                chk("rnd_wr_order", ok, 1);
                model[wa] = wd;
            end
            if (acc_a) aq.push_back('{a: alu_addr, d: alu_data});
            if (acc_m) mq.push_back('{a: mem_addr, d: mem_data});
            last_rg = rg;
            last_ra = rd_addr;
        end
        chk("rnd_drained", aq.size() + mq.size(), 0);
        chk("rnd_idle", idle, 1);
    endtask

    initial begin
        vec_t          vt [8];
        int            n0, waits, ai, mi, na, nm;
        bit            rd_on, rd_done, a_acc, m_acc, r_acc, seen;
        logic [DW-1:0] got;

        vt[0] = '{1'b0, 1'b0, 4'd11, 16'h0008};
        vt[1] = '{1'b0, 1'b1, 4'd2,  16'h1234};
        vt[2] = '{1'b0, 1'b0, 4'd0,  16'hFFFF};
        vt[3] = '{1'b0, 1'b1, 4'd15, 16'h0001};
        vt[4] = '{1'b1, 1'b0, 4'd11, 16'h0008};
        vt[5] = '{1'b1, 1'b0, 4'd2,  16'h1234};
        vt[6] = '{1'b1, 1'b0, 4'd0,  16'hFFFF};
        vt[7] = '{1'b1, 1'b0, 4'd15, 16'h0001};

        rst_n = 1'b0; clr_mem = 1'b1;
        alu_valid = 0; alu_addr = '0; alu_data = '0;
        mem_valid = 0; mem_addr = '0; mem_data = '0;
        rd_valid = 0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check_reset_outs("rst_hold");
        rst_n = 1'b1; clr_mem = 1'b0;
        @(negedge clk);
        check_reset_outs("rst_rel");

        for (int i = 0; i < 8; i++) begin
            if (!vt[i].is_rd) begin
                @(negedge clk);
                alu_valid = !vt[i].on_mem;
                mem_valid = vt[i].on_mem;
                alu_addr = vt[i].addr; alu_data = vt[i].data;
                mem_addr = vt[i].addr; mem_data = vt[i].data;
                #1;
                chk("vec_ready", vt[i].on_mem ? mem_ready : alu_ready, 1);
                @(negedge clk);
                alu_valid = 0; mem_valid = 0;
                chk("vec_pend_e0", pending[vt[i].addr], 1);
                chk("vec_wre_e0", rf_wre, 0);
                @(negedge clk);
                chk("vec_wre_e1", rf_wre, 1);
                chk("vec_a3_e1", rf_a3, vt[i].addr);
                chk("vec_wd3_e1", rf_wd3, vt[i].data);
                chk("vec_pend_e1", pending[vt[i].addr], 1);
                @(negedge clk);
                chk("vec_pend_e2", pending, 0);
                chk("vec_idle_e2", idle, 1);
                chk("vec_wre_e2", rf_wre, 0);
            end else begin
                do_read("vec_rd", vt[i].addr, vt[i].data);
                @(negedge clk);
                chk("vec_rd_done", rd_data_valid, 0);
            end
        end

        n0 = wlog.size();
        push_pair("rr1", 4'd9, 16'h1111, 4'd7, 16'h2222);
        wait_idle("rr1_idle");
        chk("rr1_cnt", wlog.size() - n0, 2);
        chk("rr1_first", wlog[n0], {4'd9, 16'h1111});
        chk("rr1_second", wlog[n0 + 1], {4'd7, 16'h2222});

        push_one(1'b0, 4'd10, 16'h0A0A);
        wait_idle("lone_idle");
        n0 = wlog.size();
        push_pair("rr2", 4'd9, 16'h3333, 4'd7, 16'h4444);
        wait_idle("rr2_idle");
        chk("rr2_first", wlog[n0], {4'd7, 16'h4444});
        chk("rr2_second", wlog[n0 + 1], {4'd9, 16'h3333});

        @(negedge clk);
        alu_valid = 1; alu_addr = 4'd9; alu_data = 16'hBEEF;
        @(negedge clk);
        alu_valid = 0;
        rd_valid = 1; rd_addr = 4'd9;
        waits = 0;
        #1;
        while (!rd_ready && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        chk("raw_waits", waits, 2);
        chk("raw_pend", pending[9], 0);
        @(negedge clk);
        rd_valid = 0;
        chk("raw_rdv", rd_data_valid, 1);
        chk("raw_data", rd_data, 16'hBEEF);
        wait_idle("raw_idle");

        push_one(1'b1, 4'd14, 16'h0E0E);
        wait_idle("lone2_idle");
        push_pair("waw", 4'd3, 16'hAAAA, 4'd3, 16'hBBBB);
        chk("waw_pend_e0", pending[3], 1);
        @(negedge clk);
        chk("waw_wre1", rf_wre, 1);
        chk("waw_wd1", rf_wd3, 16'hAAAA);
        chk("waw_pend1", pending[3], 1);
        @(negedge clk);
        chk("waw_wre2", rf_wre, 1);
        chk("waw_wd2", rf_wd3, 16'hBBBB);
        chk("waw_pend2", pending[3], 1);
        @(negedge clk);
        chk("waw_pend_clr", pending[3], 0);
        chk("waw_idle", idle, 1);
        do_read("waw_rd", 4'd3, 16'hBBBB);
        wait_idle("waw_rd_idle");

        n0 = wlog.size();
        ai = 0; mi = 0; waits = 0;
        rd_on = 0; rd_done = 0; seen = 0; got = '0;
        for (int c = 0; c < 40 && !(rd_done && ai == 4 && mi == 4); c++) begin
            @(negedge clk);
            if (rd_data_valid) begin seen = 1; got = rd_data; end
            alu_valid = (ai < 4);
            alu_addr  = AW'(1 + ai);
            alu_data  = DW'(16'hA100 + ai);
            mem_valid = (mi < 4);
            mem_addr  = AW'(5 + mi);
            mem_data  = DW'(16'hB500 + mi);
            rd_valid  = rd_on && !rd_done;
            rd_addr   = 4'd15;
            #1;
            if (rd_valid && !rd_ready) waits++;
            a_acc = alu_valid && alu_ready;
            m_acc = mem_valid && mem_ready;
            r_acc = rd_valid && rd_ready;
            @(posedge clk);
            if (a_acc) ai++;
            if (m_acc) mi++;
            if (r_acc) rd_done = 1;
            rd_on = 1;
        end
        @(negedge clk);
        if (rd_data_valid) begin seen = 1; got = rd_data; end
        alu_valid = 0; mem_valid = 0; rd_valid = 0;
        chk("starve_waits", waits, SMAX);
        chk("starve_rd_seen", seen, 1);
        chk("starve_rd_data", got, 16'h0001);
        wait_idle("starve_idle");
        na = 0; nm = 0;
        for (int i = n0; i < wlog.size(); i++) begin
            if (wlog[i][19:16] >= 1 && wlog[i][19:16] <= 4) begin
                chk("starve_alu_ord", wlog[i], {4'(1 + na), 16'(16'hA100 + na)});
                na++;
            end else begin
                chk("starve_mem_ord", wlog[i], {4'(5 + nm), 16'(16'hB500 + nm)});
                nm++;
            end
        end
        chk("starve_alu_cnt", na, 4);
        chk("starve_mem_cnt", nm, 4);

        push_pair("pre", 4'd12, 16'hC0DE, 4'd13, 16'hD00D);
        wait_idle("pre_idle");
        @(negedge clk);
        alu_valid = 1; alu_addr = 4'd12; alu_data = 16'h1212;
        mem_valid = 1; mem_addr = 4'd13; mem_data = 16'h1313;
        @(negedge clk);
        alu_data = 16'h2121;
        mem_data = 16'h3131;
        @(posedge clk);
        #2;
        chk("mid_wre", rf_wre, 1);
        chk("mid_full", idle, 0);
        rst_n = 1'b0;
        alu_valid = 0; mem_valid = 0;
        #1;
        check_reset_outs("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outs("post_rst");
        do_read("post_r12", 4'd12, 16'hC0DE);
        do_read("post_r13", 4'd13, 16'hD00D);
        wait_idle("post_idle");

        rand_phase(1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
